pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the write-enable, flush and bubble controls of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use stalls, branch/jump flushes resolved in EX, and multi-cycle data-memory waits. It also keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters.
- MEM_TIMEOUT, 255, number of consecutive MEM_WAIT cycles after which mem_timeout is set (1..2^16-1).

Ports:
- clk  in  1  pipeline clock; state updates on negedge, the same edge as the pipeline registers.
- reset  in  1  reset, asynchronous, active-low.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq/bne, sw).
- ex_mem_read  in  1  MemRead_out of the ID/EX register.
- ex_rt  in  5  rt field of the instruction in EX.
- ex_branch_taken  in  1  (BranchEQ & zero) | (BranchNE & ~zero) resolved in EX.
- ex_jump  in  1  Jump_out of the ID/EX register.
- mem_req  in  1  MEM stage is performing a load or store.
- mem_ready  in  1  data memory has completed the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID enable.
- if_id_flush  out  1  load NOP (0x00000000) into IF/ID.
- id_ex_write  out  1  ID/EX enable.
- id_ex_bubble  out  1  zero all control fields entering ID/EX.
- ex_mem_write  out  1  EX/MEM and MEM/WB enable.
- stall_cnt  out  CNT_W  cycles with pc_write=0, saturating.
- flush_cnt  out  CNT_W  flush events, saturating.
- mem_timeout  out  1  sticky: one memory wait reached MEM_TIMEOUT cycles.

## Operation
- States: RUN, MEM_WAIT. Reset state is RUN.
- Outputs are Mealy (combinational from state and inputs). Priority from highest: memory wait, flush, load-use, normal.
- Memory wait condition: (state==MEM_WAIT) or (state==RUN and mem_req and not mem_ready).
  - All enables are 0: pc_write, if_id_write, id_ex_write, ex_mem_write.
  - No flush and no bubble are issued.
- Flush (RUN, no memory wait, ex_branch_taken|ex_jump):
  - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_bubble=1, ex_mem_write=1.
  - flush_cnt increments.
- Load-use (RUN, no wait, no flush, ex_mem_read=1, ex_rt!=0, and ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)):
  - pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1, ex_mem_write=1.
- Normal: all enables 1; flush and bubble are 0.
- Transitions:
  - RUN to MEM_WAIT when mem_req & ~mem_ready.
  - MEM_WAIT to RUN when mem_ready.
  - MEM_WAIT self-loops otherwise.
- In the MEM_WAIT cycle where mem_ready=1, outputs are still the frozen set. The next cycle is evaluated in RUN.
- A branch or jump held in EX during a wait is re-evaluated after the wait. Its flush is therefore never lost and never issued twice.
- Wait counter (internal, 16 bit):
  - Cleared on every entry into MEM_WAIT.
  - Increments each MEM_WAIT cycle.
  - Reaching MEM_TIMEOUT sets mem_timeout. mem_timeout clears only on reset.
  - The FSM keeps waiting after a timeout.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, on reset=0):
  - state=RUN; stall_cnt=0; flush_cnt=0; mem_timeout=0; wait counter=0.
  - Outputs while in reset: pc_write=1, if_id_write=1, id_ex_write=1, ex_mem_write=1, if_id_flush=0, id_ex_bubble=0. This is the RUN decode with idle inputs; for reset-value checks, idle inputs are mem_req=0 and all other inputs 0.
- Latency: stall, flush and bubble controls take effect at the next negedge after the condition appears, because they are combinational. The state register and counters update on that same negedge.
- Load-use produces exactly one bubble: after the bubble, ex_mem_read is 0.
- Reset asserted during MEM_WAIT returns to RUN immediately. The pending access is abandoned.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state encoding (RUN=0, MEM_WAIT=1);
  - the NOP constant 32'h0;
  - register number 0 as a constant.
- Sub-module hazard_sat_counter (parameter W; ports: clk, reset, inc, count) is used for stall_cnt and flush_cnt.

## Test plan
- Load-use: lw $t0 in EX (ex_mem_read=1, ex_rt=8), add in ID with id_rs=8 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1.
- Register 0 and unused rt:
  - ex_rt=0, id_rs=0 -> no stall.
  - ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
- Flush beats load-use: ex_branch_taken=1 together with a load-use match -> pc_write=1, if_id_flush=1, id_ex_bubble=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait:
  - mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> 4 cycles with all enables 0; stall_cnt=4; state returns to RUN.
  - A concurrent ex_jump=1 flushes only once, in the cycle after the wait.
- Timeout: MEM_TIMEOUT=4 and mem_ready held at 0 -> mem_timeout rises after the 4th MEM_WAIT cycle and stays 1 after mem_ready; cleared by reset=0.
- Saturation and async reset:
  - CNT_W=2 with 5 flushes -> flush_cnt=3.
  - Async reset pulsed between clock edges mid-wait -> state=RUN and all counters 0 immediately.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   ctrl_state_e  : controller FSM state encoding (RUN=0, MEM_WAIT=1)
//   pipe_ctrl_t   : bundle of pipeline-register control strobes
//   NOP_INSTR     : instruction word loaded into IF/ID on a flush
//   REG_ZERO      : hard-wired zero register number
package pipeline_ctrl_pkg;

  localparam int unsigned WAIT_CNT_W = 16;
  localparam int unsigned REG_W      = 5;

  localparam logic [31:0]      NOP_INSTR = 32'h0000_0000;
  localparam logic [REG_W-1:0] REG_ZERO  = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                         id_ex_write: 1'b1, id_ex_bubble: 1'b0, ex_mem_write: 1'b1};
  localparam pipe_ctrl_t CTRL_FROZEN = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_write: 1'b0, id_ex_bubble: 1'b0, ex_mem_write: 1'b0};
  localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                         id_ex_write: 1'b1, id_ex_bubble: 1'b1, ex_mem_write: 1'b1};
  localparam pipe_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_write: 1'b1, id_ex_bubble: 1'b1, ex_mem_write: 1'b1};

  // Load in EX writes a register the ID instruction reads; $zero never creates a dependency.
  function automatic logic load_use_hazard(
    input logic             ex_mem_read,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt,
    input logic             id_uses_rt
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter, updated on the pipeline (falling) clock edge.
//   clk   : pipeline clock
//   reset : asynchronous, active-low clear
//   inc   : count one event this cycle
//   count : current value, holds at all-ones
module hazard_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline.
// Produces Mealy enable/flush/bubble strobes for PC, IF/ID, ID/EX and EX/MEM,
// covering data-memory waits, EX-resolved branch/jump flushes and load-use stalls.
//   clk, reset           : pipeline clock (falling-edge state), async active-low reset
//   id_rs/id_rt/id_uses_rt, ex_mem_read/ex_rt : load-use detection inputs
//   ex_branch_taken/ex_jump                   : control transfer resolved in EX
//   mem_req/mem_ready                         : data-memory handshake
//   pc_write .. ex_mem_write                  : pipeline control strobes
//   stall_cnt/flush_cnt                       : saturating performance counters
//   mem_timeout                               : sticky long-wait indicator
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(MEM_TIMEOUT);

  ctrl_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_inc;
  logic                  timeout_q;
  pipe_ctrl_t            ctrl;
  logic                  mem_wait;
  logic                  flush;

  // Decode: memory wait > flush > load-use > normal.
  always_comb begin
    ctrl     = CTRL_NORMAL;
    state_d  = state_q;
    mem_wait = 1'b0;
    flush    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          mem_wait = 1'b1;
          state_d  = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // The completing cycle is still frozen; decode resumes next cycle in RUN.
        mem_wait = 1'b1;
        if (mem_ready) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (mem_wait) begin
      ctrl = CTRL_FROZEN;
    end else if (ex_branch_taken || ex_jump) begin
      ctrl  = CTRL_FLUSH;
      flush = 1'b1;
    end else if (load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt)) begin
      ctrl = CTRL_STALL;
    end
  end

  assign wait_cnt_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);

  // State, wait-length counter and sticky timeout.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == RUN) && (state_d == MEM_WAIT)) begin
        wait_cnt_q <= '0;
      end else if (state_q == MEM_WAIT) begin
        wait_cnt_q <= wait_cnt_inc;
        if (wait_cnt_inc >= TIMEOUT_LIM) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_write  = ctrl.id_ex_write;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign mem_timeout  = timeout_q;

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!ctrl.pc_write),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: three instances share stimulus
// (default parameters, MEM_TIMEOUT=4, CNT_W=2). Expected strobe vectors are
// queued when stimulus is driven and compared by a monitor after settling.
module tb_pipeline_hazard_ctrl;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write}
  localparam logic [5:0] NORM = 6'b110101;
  localparam logic [5:0] FLSH = 6'b111111;
  localparam logic [5:0] LDU  = 6'b000111;
  localparam logic [5:0] FRZ  = 6'b000000;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, ex_jump, mem_req, mem_ready;

  logic        pc_a, ifw_a, iff_a, idw_a, idb_a, exw_a, to_a;
  logic [15:0] stall_a, flush_a;
  logic        pc_t, ifw_t, iff_t, idw_t, idb_t, exw_t, to_t;
  logic [15:0] stall_t, flush_t;
  logic        pc_s, ifw_s, iff_s, idw_s, idb_s, exw_s, to_s;
  logic [1:0]  stall_s, flush_s;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_jump(ex_jump), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_a), .if_id_write(ifw_a), .if_id_flush(iff_a), .id_ex_write(idw_a),
    .id_ex_bubble(idb_a), .ex_mem_write(exw_a), .stall_cnt(stall_a), .flush_cnt(flush_a),
    .mem_timeout(to_a));

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_jump(ex_jump), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_t), .if_id_write(ifw_t), .if_id_flush(iff_t), .id_ex_write(idw_t),
    .id_ex_bubble(idb_t), .ex_mem_write(exw_t), .stall_cnt(stall_t), .flush_cnt(flush_t),
    .mem_timeout(to_t));

  pipeline_hazard_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_jump(ex_jump), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_s), .if_id_write(ifw_s), .if_id_flush(iff_s), .id_ex_write(idw_s),
    .id_ex_bubble(idb_s), .ex_mem_write(exw_s), .stall_cnt(stall_s), .flush_cnt(flush_s),
    .mem_timeout(to_s));

  // Scoreboard monitor: strobes settle after the posedge drive, well before the negedge.
  always begin
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      logic [5:0] e, o;
      e = exp_q.pop_front();
      o = {pc_a, ifw_a, iff_a, idw_a, idb_a, exw_a};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL strobes t=%0t got=%b want=%b", $time, o, e);
      end
      checks++;
      if ({pc_s, ifw_s, iff_s, idw_s, idb_s, exw_s, pc_t, ifw_t, iff_t, idw_t, idb_t, exw_t} !== {e, e}) begin
        errors++;
        $display("FAIL strobes_param t=%0t got_s=%b got_t=%b want=%b", $time,
                 {pc_s, ifw_s, iff_s, idw_s, idb_s, exw_s},
                 {pc_t, ifw_t, iff_t, idw_t, idb_t, exw_t}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Drive one cycle's inputs (called just after posedge) and queue the expected strobes.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] xrt, input logic bt, input logic jmp,
                       input logic mreq, input logic mrdy, input logic [5:0] e);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mr; ex_rt = xrt;
    ex_branch_taken = bt; ex_jump = jmp; mem_req = mreq; mem_ready = mrdy;
    exp_q.push_back(e);
    if (e[5] == 1'b0) exp_stall++;
    if (e[3] == 1'b1) exp_flush++;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    void'(exp_q.pop_back());
    exp_stall = 0; exp_flush = 0;
    #2;
    checks++;
    if ({pc_a, ifw_a, iff_a, idw_a, idb_a, exw_a} !== NORM) begin
      errors++;
      $display("FAIL reset_strobes got=%b want=%b", {pc_a, ifw_a, iff_a, idw_a, idb_a, exw_a}, NORM);
    end
    checks++;
    if ({stall_a, flush_a, to_a} !== 33'd0) begin
      errors++;
      $display("FAIL reset_counters stall=%0d flush=%0d timeout=%b want 0 0 0", stall_a, flush_a, to_a);
    end
    @(posedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_load_use;
    @(posedge clk); drive(5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, LDU);
    @(negedge clk); #1;
    checks++;
    if (stall_a !== 16'd1) begin
      errors++; $display("FAIL load_use_stall_cnt got=%0d want=1", stall_a);
    end
    // After the bubble the load has moved on: no second stall.
    @(posedge clk); drive(5'd8, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    @(negedge clk); #1;
    // rt dependency when the instruction reads rt.
    @(posedge clk); drive(5'd2, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, LDU);
    @(negedge clk); #1;
    checks++;
    if (stall_a !== 16'(exp_stall)) begin
      errors++; $display("FAIL load_use_rt_stall_cnt got=%0d want=%0d", stall_a, exp_stall);
    end
  endtask

  task automatic test_no_stall;
    @(posedge clk); drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    @(negedge clk); #1;
    @(posedge clk); drive(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    @(negedge clk); #1;
    checks++;
    if (stall_a !== 16'd2) begin
      errors++; $display("FAIL no_stall_cnt got=%0d want=2", stall_a);
    end
  endtask

  task automatic test_flush_priority;
    @(posedge clk); drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, FLSH);
    @(negedge clk); #1;
    checks++;
    if (flush_a !== 16'd1 || stall_a !== 16'd2) begin
      errors++; $display("FAIL flush_priority_cnts flush=%0d stall=%0d want 1 2", flush_a, stall_a);
    end
  endtask

  task automatic test_mem_wait;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ);
      @(negedge clk); #1;
    end
    @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, FRZ);
    @(negedge clk); #1;
    checks++;
    if (stall_a !== 16'd6 || flush_a !== 16'd1) begin
      errors++; $display("FAIL mem_wait_cnts stall=%0d flush=%0d want 6 1", stall_a, flush_a);
    end
    // Jump held through the wait flushes exactly once, now that state is RUN.
    @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FLSH);
    @(negedge clk); #1;
    @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    @(negedge clk); #1;
    checks++;
    if (flush_a !== 16'd2 || to_t !== 1'b0) begin
      errors++; $display("FAIL mem_wait_jump_once flush=%0d timeout=%b want 2 0", flush_a, to_t);
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ);
      @(negedge clk); #1;
      checks++;
      if (to_t !== (i == 4)) begin
        errors++; $display("FAIL timeout_rise cycle=%0d got=%b want=%b", i, to_t, (i == 4));
      end
    end
    @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, FRZ);
    @(negedge clk); #1;
    @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    @(negedge clk); #1;
    checks++;
    if (to_t !== 1'b1 || to_a !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky got_t=%b got_a=%b want 1 0", to_t, to_a);
    end
    checks++;
    if (stall_a !== 16'(exp_stall)) begin
      errors++; $display("FAIL timeout_stall_cnt got=%0d want=%0d", stall_a, exp_stall);
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ);
    @(negedge clk); #1;
    @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ);
    @(negedge clk); #1;
    @(posedge clk); #3;
    checks++;
    if (pc_a !== 1'b0) begin
      errors++; $display("FAIL async_reset_pre_wait pc_write got=%b want=0", pc_a);
    end
    reset = 1'b0;
    #1;
    exp_stall = 0; exp_flush = 0;
    checks++;
    if ({pc_a, ifw_a, iff_a, idw_a, idb_a, exw_a} !== NORM) begin
      errors++; $display("FAIL async_reset_strobes got=%b want=%b", {pc_a, ifw_a, iff_a, idw_a, idb_a, exw_a}, NORM);
    end
    checks++;
    if (stall_a !== 16'd0 || flush_a !== 16'd0 || to_t !== 1'b0) begin
      errors++; $display("FAIL async_reset_counters stall=%0d flush=%0d timeout=%b want 0 0 0", stall_a, flush_a, to_t);
    end
    #1 reset = 1'b1;
    @(negedge clk); #1;
    @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    @(negedge clk); #1;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FLSH);
      @(negedge clk); #1;
    end
    checks++;
    if (flush_s !== 2'd3 || flush_a !== 16'd5) begin
      errors++; $display("FAIL saturation flush_s=%0d flush_a=%0d want 3 5", flush_s, flush_a);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ);
      @(negedge clk); #1;
    end
    @(posedge clk); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ);
    @(negedge clk); #1;
    checks++;
    if (stall_s !== 2'd3 || stall_a !== 16'(exp_stall)) begin
      errors++; $display("FAIL saturation_stall stall_s=%0d stall_a=%0d want 3 %0d", stall_s, stall_a, exp_stall);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_flush_priority();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_saturation();
    @(posedge clk); #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
